// File: rtl/spi_tx_word_buffer_if.sv
// Bundle of producer-side and SPI-side signals for spi_tx_word_buffer.
// The slave modport is the buffer; the master modport is the producer/SPI side.
// Signal prefixes (i_/o_) are from the buffer's point of view.
interface spi_tx_word_buffer_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             i_wr_en;
  logic [15:0]      i_wr_data;
  logic             o_full;
  logic             o_empty;
  logic [CW-1:0]    o_count;
  logic             o_overflow;
  logic             i_csbar;
  logic [15:0]      o_data;
  logic             o_loaded;
  logic             o_underrun;
  logic [CNT_W-1:0] o_frame_cnt;
  logic [CNT_W-1:0] o_underrun_cnt;

  modport slave (
    input  i_wr_en, i_wr_data, i_csbar,
    output o_full, o_empty, o_count, o_overflow,
           o_data, o_loaded, o_underrun, o_frame_cnt, o_underrun_cnt
  );

  modport master (
    output i_wr_en, i_wr_data, i_csbar,
    input  o_full, o_empty, o_count, o_overflow,
           o_data, o_loaded, o_underrun, o_frame_cnt, o_underrun_cnt
  );
endinterface

// File: rtl/spi_tx_word_buffer.sv
// SPI transmit word buffer: a DEPTH-word FIFO feeding the parallel-load
// register of an SPI slave. A word is popped into o_data while chip select
// is idle-high and held frozen for the whole frame.
// Optional statistics counters are enabled by defining SPI_TXBUF_STATS_EN;
// without it o_frame_cnt / o_underrun_cnt are tied to zero.
module spi_tx_word_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  spi_tx_word_buffer_if.slave   io_bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOADED, S_BUSY, S_DONE} state_t;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          r_cs_meta;
  logic          r_cs_sync;
  logic          r_cs_prev;

  state_t        r_state;
  logic [15:0]   r_data;
  logic          r_loaded;
  logic          r_underrun;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_cs_fall;
  logic          w_cs_rise;

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_push    = io_bus.i_wr_en & ~w_full;
  // Pop only while chip select is idle-high, so o_data never moves mid-frame.
  assign w_pop     = (r_state == S_IDLE) & r_cs_sync & ~w_empty;
  assign w_cs_fall = r_cs_prev & ~r_cs_sync;
  assign w_cs_rise = ~r_cs_prev & r_cs_sync;

  // Two-flop synchronizer plus a delayed copy for edge detection; idles high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cs_meta <= 1'b1;
      r_cs_sync <= 1'b1;
      r_cs_prev <= 1'b1;
    end else begin
      r_cs_meta <= io_bus.i_csbar;
      r_cs_sync <= r_cs_meta;
      r_cs_prev <= r_cs_sync;
    end
  end

  // FIFO storage: plain array, written without reset so it maps to RAM.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= io_bus.i_wr_data;
    end
  end

  // FIFO pointers, occupancy and the dropped-write pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= io_bus.i_wr_en & w_full;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame state machine; owns o_data (registered RAM read), loaded flag and underrun pulse.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_data     <= 16'h0000;
      r_loaded   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            // Frame began with nothing loaded: the slave shifts stale data.
            r_underrun <= 1'b1;
            r_state    <= S_BUSY;
          end else if (w_pop) begin
            r_data   <= r_mem[r_rd_ptr];
            r_loaded <= 1'b1;
            r_state  <= S_LOADED;
          end
        end
        S_LOADED: begin
          if (w_cs_fall) begin
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_cs_rise) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_loaded <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SPI_TXBUF_STATS_EN
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_underrun_cnt;

  // Saturating frame and underrun counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_frame_cnt    <= '0;
      r_underrun_cnt <= '0;
    end else begin
      if ((r_state == S_BUSY) && w_cs_rise && (r_frame_cnt != '1)) begin
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
      if (r_underrun && (r_underrun_cnt != '1)) begin
        r_underrun_cnt <= r_underrun_cnt + CNT_W'(1);
      end
    end
  end

  assign io_bus.o_frame_cnt    = r_frame_cnt;
  assign io_bus.o_underrun_cnt = r_underrun_cnt;
`else
  assign io_bus.o_frame_cnt    = {CNT_W{1'b0}};
  assign io_bus.o_underrun_cnt = {CNT_W{1'b0}};
`endif

  assign io_bus.o_full     = w_full;
  assign io_bus.o_empty    = w_empty;
  assign io_bus.o_count    = r_count;
  assign io_bus.o_overflow = r_overflow;
  assign io_bus.o_data     = r_data;
  assign io_bus.o_loaded   = r_loaded;
  assign io_bus.o_underrun = r_underrun;
endmodule

// File: doc/spi_tx_word_buffer.md
SPI_TX_WORD_BUFFER -- requirements
Module: spi_tx_word_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning FIFO word depth (power of two, 2..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of the statistics counters.
REQ-003 CLK  input  1  system clock; one clock only, all logic on its rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 WR_EN  input  1  producer write strobe, one word per CLK cycle when high.
REQ-006 WR_DATA  input  16  producer sample word.
REQ-007 FULL  output  1  FIFO holds DEPTH words.
REQ-008 EMPTY  output  1  FIFO holds zero words.
REQ-009 COUNT  output  log2(DEPTH)+1  FIFO occupancy.
REQ-010 OVERFLOW  output  1  one-cycle pulse: write dropped because FIFO was full.
REQ-011 CSbar  input  1  SPI chip select, active low, asynchronous to CLK.
REQ-012 DATA  output  16  word presented to the SPI slave's parallel load input.
REQ-013 LOADED  output  1  DATA holds an unsent FIFO word.
REQ-014 UNDERRUN  output  1  one-cycle pulse: frame started with no word loaded.
REQ-015 FRAME_CNT, UNDERRUN_CNT  output  CNT_W each  statistics (see Configuration).

Function
REQ-016 CSbar SHALL pass through a 2-flop synchronizer; rising/falling edges SHALL be detected on the synchronized signal against a third registered copy.
REQ-017 FIFO write SHALL occur when WR_EN=1 and FULL=0; WR_EN=1 with FULL=1 SHALL drop the word and pulse OVERFLOW next cycle.
REQ-018 Simultaneous write and pop SHALL both succeed, COUNT unchanged; pointers SHALL wrap modulo DEPTH.
REQ-019 State machine states: IDLE, LOADED, BUSY, DONE.
REQ-020 IDLE: if synchronized CSbar=1 and EMPTY=0, pop head word into DATA, go LOADED; if CSbar falling edge, pulse UNDERRUN, go BUSY with DATA unchanged.
REQ-021 LOADED: DATA frozen; on CSbar falling edge go BUSY.
REQ-022 BUSY: DATA frozen; on CSbar rising edge go DONE.
REQ-023 DONE: clear LOADED; go IDLE next cycle.
REQ-024 DATA SHALL change only on the IDLE->LOADED transition; it SHALL never change while synchronized CSbar=0.
REQ-025 LOADED output SHALL be 1 exactly in states LOADED and BUSY-entered-from-LOADED.
REQ-026 Latency: WR_DATA written at edge N into an empty FIFO with CSbar high and state IDLE SHALL appear on DATA after edge N+1.
REQ-027 After CSbar rises, next FIFO word SHALL be on DATA no later than 5 CLK edges later; master SHALL hold CSbar high at least 6 CLK before the next SCK edge.
REQ-028 A CSbar glitch shorter than one CLK period MAY be missed; a detected low pulse SHALL count as a full frame.

Reset
REQ-029 RESET SHALL force: state IDLE, FIFO empty (COUNT=0, EMPTY=1, FULL=0), DATA=16'h0000, LOADED=0, OVERFLOW=0, UNDERRUN=0, synchronizer flops=1, counters=0.
REQ-030 RESET asserted mid-frame SHALL discard the loaded word; if CSbar is low at reset release, the falling edge detected SHALL be treated as an underrun frame.

Configuration
REQ-031 Macro SPI_TXBUF_STATS_EN defined: FRAME_CNT SHALL increment on every BUSY->DONE transition and UNDERRUN_CNT on every UNDERRUN pulse, both saturating at all-ones.
REQ-032 SPI_TXBUF_STATS_EN undefined: FRAME_CNT and UNDERRUN_CNT SHALL be constant zero, no counter registers synthesized.

Verification
REQ-033 Write 16'hA5C3 with CSbar high -> DATA=16'hA5C3, LOADED=1 after one further edge; COUNT=0.
REQ-034 Write 1,2,3; run three 16-SCK frames -> DATA sequence 1,2,3 each stable throughout its frame; EMPTY=1 at end.
REQ-035 Write 9 words with DEPTH=8, none popped (CSbar low from start) -> FULL=1, one OVERFLOW pulse, 9th word never appears.
REQ-036 CSbar falls with FIFO empty -> UNDERRUN pulse, DATA unchanged 16'h0000; with STATS_EN UNDERRUN_CNT=1, FRAME_CNT=1 after CSbar rises.
REQ-037 Write and pop in same cycle at COUNT=4 -> COUNT stays 4; pointers wrap past DEPTH-1 without data corruption.
REQ-038 Assert RESET during BUSY with DATA=16'h1234 -> next cycle DATA=0, LOADED=0, COUNT=0, state IDLE.
